// File: rtl/ili9341_rect_fill_if.sv
// ili9341_rect_fill_if: fill-command handshake and frame-buffer write port of the rectangle-fill engine
interface ili9341_rect_fill_if #(
    parameter int ADDR_W = 17
);
    logic              cmdValid;
    logic              cmdReady;
    logic [7:0]        cmdX0;
    logic [7:0]        cmdX1;
    logic [8:0]        cmdY0;
    logic [8:0]        cmdY1;
    logic [15:0]       cmdColor;
    logic              cmdOutline;
    logic              fbWrEn;
    logic [ADDR_W-1:0] fbWrAddr;
    logic [15:0]       fbWrData;
    logic              fbWrReady;
    logic              busy;
    logic              done;

    modport master (
        output cmdValid, cmdX0, cmdX1, cmdY0, cmdY1, cmdColor, cmdOutline, fbWrReady,
        input  cmdReady, fbWrEn, fbWrAddr, fbWrData, busy, done
    );

    modport slave (
        input  cmdValid, cmdX0, cmdX1, cmdY0, cmdY1, cmdColor, cmdOutline, fbWrReady,
        output cmdReady, fbWrEn, fbWrAddr, fbWrData, busy, done
    );
endinterface

// File: rtl/ili9341_rect_fill.sv
// ili9341_rect_fill: walks a rectangle row-major and writes one RGB565 pixel per accepted cycle
// into the ILI9341 frame buffer. Define RECT_FILL_OUTLINE_EN to honour cmdOutline (border only).
module ili9341_rect_fill #(
    parameter int COLS_  = 240,
    parameter int ROWS_  = 320,
    parameter int ADDR_W = 17
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    ili9341_rect_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [7:0] X_MAX = 8'(COLS_ - 1);
    localparam logic [8:0] Y_MAX = 9'(ROWS_ - 1);

    state_t            state, nextState;
    logic [7:0]        xL, xR, x, xLo, xHi, xNext;
    logic [8:0]        yT, yB, y, yLo, yHi;
    logic [ADDR_W-1:0] rowBase, rowInit;
    logic [15:0]       color;
    logic              empty, fire, lastX, lastY;
`ifdef RECT_FILL_OUTLINE_EN
    logic              outline;
`else
    logic              unusedOutline;
    assign unusedOutline = bus.cmdOutline;
`endif

    // Order the latched raw bounds; first row base is a shift-add of the constant column count
    always_comb begin
        xLo   = (xL < xR) ? xL : xR;
        xHi   = (xL < xR) ? xR : xL;
        yLo   = (yT < yB) ? yT : yB;
        yHi   = (yT < yB) ? yB : yT;
        empty = (xLo > X_MAX) || (yLo > Y_MAX);
        rowInit = '0;
        for (int i = 0; i < ADDR_W; i++)
            rowInit = COLS_[i] ? rowInit + (ADDR_W'(yLo) << i) : rowInit;
    end

    // Cursor stepping; in outline mode middle rows jump straight from left to right edge
    always_comb begin
        fire  = (state == FILL) && bus.fbWrReady;
        lastX = (x == xR);
        lastY = (y == yB);
`ifdef RECT_FILL_OUTLINE_EN
        xNext = (outline && x == xL && y != yT && y != yB) ? xR : x + 8'd1;
`else
        xNext = x + 8'd1;
`endif
    end

    // State register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.cmdValid ? SETUP : IDLE;
            SETUP:   nextState = empty ? DONE : FILL;
            FILL:    nextState = (fire && lastX && lastY) ? DONE : FILL;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from state; address is the running row base plus the column
    always_comb begin
        bus.cmdReady = (state == IDLE);
        bus.busy     = (state != IDLE);
        bus.fbWrEn   = (state == FILL);
        bus.done     = (state == DONE);
        bus.fbWrAddr = rowBase + ADDR_W'(x);
        bus.fbWrData = color;
    end

    // Command latch, bound normalisation and pixel cursor
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            xL      <= '0;
            xR      <= '0;
            yT      <= '0;
            yB      <= '0;
            x       <= '0;
            y       <= '0;
            rowBase <= '0;
            color   <= '0;
`ifdef RECT_FILL_OUTLINE_EN
            outline <= 1'b0;
`endif
        end else if (state == IDLE && bus.cmdValid) begin
            xL    <= bus.cmdX0;
            xR    <= bus.cmdX1;
            yT    <= bus.cmdY0;
            yB    <= bus.cmdY1;
            color <= bus.cmdColor;
`ifdef RECT_FILL_OUTLINE_EN
            outline <= bus.cmdOutline;
`endif
        end else if (state == SETUP) begin
            xL      <= xLo;
            xR      <= (xHi > X_MAX) ? X_MAX : xHi;
            yT      <= yLo;
            yB      <= (yHi > Y_MAX) ? Y_MAX : yHi;
            x       <= xLo;
            y       <= yLo;
            rowBase <= rowInit;
        end else if (fire) begin
            x <= lastX ? xL : xNext;
            if (lastX && !lastY) begin
                y       <= y + 9'd1;
                rowBase <= rowBase + ADDR_W'(COLS_);
            end
        end
    end
endmodule

// File: tb/tb_ili9341_rect_fill.sv
// tb_ili9341_rect_fill: scoreboard bench for the rectangle-fill engine
module tb_ili9341_rect_fill;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic CLK_I = 1'b0;
    logic RST_I;

    ili9341_rect_fill_if bus();

    ili9341_rect_fill dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .bus  (bus)
    );

    always #5 CLK_I = ~CLK_I;

    int          nChecks = 0;
    int          nErrors = 0;
    exp_t        expQ[$];
    exp_t        monE;
    bit          written[int];
    int          negCnt = 0;
    int          acceptNeg = 0;
    int          firstLat = -1;
    bit          gotFirst = 1'b0;
    int          doneLat = -1;
    int          doneCnt = 0;
    int          wrCnt = 0;
    logic [31:0] lastAddr = '0;
    bit          holdPending = 1'b0;
    logic [31:0] prevAddr, prevData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Monitor: sample at negedge, compare accepted writes against the scoreboard
    always @(negedge CLK_I) begin
        negCnt++;
        if (!RST_I) holdPending = 1'b0;
        else begin
            if (bus.cmdValid && bus.cmdReady) begin
                acceptNeg = negCnt;
                gotFirst  = 1'b0;
            end
            if (holdPending) begin
                check("holdEn", bus.fbWrEn, 1);
                check("holdAddr", 32'(bus.fbWrAddr), prevAddr);
                check("holdData", 32'(bus.fbWrData), prevData);
            end
            if (bus.fbWrEn) begin
                check("busyInFill", bus.busy, 1);
                check("readyInFill", bus.cmdReady, 0);
                if (!gotFirst) begin
                    firstLat = negCnt - acceptNeg;
                    gotFirst = 1'b1;
                end
                if (bus.fbWrReady) begin
                    check("wrQueued", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        monE = expQ.pop_front();
                        check("wrAddr", 32'(bus.fbWrAddr), monE.addr);
                        check("wrData", 32'(bus.fbWrData), monE.data);
                    end
                    written[int'(bus.fbWrAddr)] = 1'b1;
                    lastAddr = 32'(bus.fbWrAddr);
                    wrCnt++;
                end
            end
            holdPending = bus.fbWrEn && !bus.fbWrReady;
            prevAddr    = 32'(bus.fbWrAddr);
            prevData    = 32'(bus.fbWrData);
            if (bus.done) begin
                doneCnt++;
                doneLat = negCnt - acceptNeg;
            end
        end
    end

    task automatic sendCmd(input logic [7:0] x0, input logic [7:0] x1, input logic [8:0] y0,
                           input logic [8:0] y1, input logic [15:0] color, input logic outline);
        int xl, xr, yt, yb;
        xl = (x0 < x1) ? int'(x0) : int'(x1);
        xr = (x0 < x1) ? int'(x1) : int'(x0);
        yt = (y0 < y1) ? int'(y0) : int'(y1);
        yb = (y0 < y1) ? int'(y1) : int'(y0);
        if (xr > 239) xr = 239;
        if (yb > 319) yb = 319;
        if (xl <= 239 && yt <= 319)
            for (int yy = yt; yy <= yb; yy++)
                for (int xx = xl; xx <= xr; xx++) begin
`ifdef RECT_FILL_OUTLINE_EN
                    if (outline && xx != xl && xx != xr && yy != yt && yy != yb) continue;
`endif
                    expQ.push_back('{32'(yy * 240 + xx), 32'(color)});
                end
        @(posedge CLK_I); #1;
        bus.cmdX0      = x0;
        bus.cmdX1      = x1;
        bus.cmdY0      = y0;
        bus.cmdY1      = y1;
        bus.cmdColor   = color;
        bus.cmdOutline = outline;
        bus.cmdValid   = 1'b1;
        @(posedge CLK_I); #1;
        bus.cmdValid   = 1'b0;
        bus.cmdX0      = 8'($urandom);
        bus.cmdX1      = 8'($urandom);
        bus.cmdY0      = 9'($urandom);
        bus.cmdY1      = 9'($urandom);
        bus.cmdColor   = 16'($urandom);
        bus.cmdOutline = 1'($urandom);
    endtask

    task automatic waitDone(input int budget, input bit toggle);
        int n, d0;
        n  = 0;
        d0 = doneCnt;
        while (doneCnt == d0 && n < budget) begin
            @(posedge CLK_I); #1;
            if (toggle) bus.fbWrReady = ~bus.fbWrReady;
            n++;
        end
        bus.fbWrReady = 1'b1;
        check("doneInTime", n < budget, 1);
        check("queueDrained", expQ.size(), 0);
    endtask

    initial begin
        int w0, d0, n;
        bus.cmdValid   = 1'b0;
        bus.cmdX0      = '0;
        bus.cmdX1      = '0;
        bus.cmdY0      = '0;
        bus.cmdY1      = '0;
        bus.cmdColor   = '0;
        bus.cmdOutline = 1'b0;
        bus.fbWrReady  = 1'b1;
        RST_I = 1'b1;
        #2 RST_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        check("rstCmdReady", bus.cmdReady, 1);
        check("rstWrEn", bus.fbWrEn, 0);
        check("rstBusy", bus.busy, 0);
        check("rstDone", bus.done, 0);
        check("rstAddr", 32'(bus.fbWrAddr), 0);
        check("rstData", 32'(bus.fbWrData), 0);
        @(negedge CLK_I); #2 RST_I = 1'b1;

        sendCmd(8'd2, 8'd4, 9'd3, 9'd4, 16'hF800, 1'b0);
        waitDone(50, 1'b0);
        check("firstLat", firstLat, 2);
        check("doneLat6", doneLat, 8);

        sendCmd(8'd4, 8'd2, 9'd0, 9'd0, 16'h07E0, 1'b0);
        waitDone(50, 1'b1);

        sendCmd(8'd230, 8'd255, 9'd318, 9'd400, 16'h001F, 1'b0);
        waitDone(100, 1'b0);
        check("clampLast", lastAddr, 76799);
        check("doneLat20", doneLat, 22);

        w0 = wrCnt;
        sendCmd(8'd250, 8'd250, 9'd10, 9'd12, 16'h1234, 1'b0);
        waitDone(20, 1'b0);
        check("emptyDoneLat", doneLat, 2);
        check("emptyWrites", wrCnt - w0, 0);

        w0 = wrCnt;
        d0 = doneCnt;
        sendCmd(8'd0, 8'd99, 9'd5, 9'd5, 16'h5A5A, 1'b0);
        n = 0;
        while (wrCnt - w0 < 3 && n < 50) begin
            @(negedge CLK_I); #2;
            n++;
        end
        check("reachThird", n < 50, 1);
        RST_I = 1'b0;
        #1;
        check("abortWrEn", bus.fbWrEn, 0);
        check("abortBusy", bus.busy, 0);
        check("abortReady", bus.cmdReady, 1);
        check("abortAddr", 32'(bus.fbWrAddr), 0);
        expQ.delete();
        @(negedge CLK_I); #2 RST_I = 1'b1;
        repeat (5) @(posedge CLK_I);
        #1;
        check("abortNoDone", doneCnt - d0, 0);

        sendCmd(8'd10, 8'd12, 9'd20, 9'd20, 16'hABCD, 1'b0);
        waitDone(30, 1'b0);
        check("afterAbortLat", doneLat, 5);

        written.delete();
        w0 = wrCnt;
        sendCmd(8'd0, 8'd3, 9'd3, 9'd0, 16'hFFFF, 1'b1);
        waitDone(50, 1'b0);
`ifdef RECT_FILL_OUTLINE_EN
        check("outlineCount", wrCnt - w0, 12);
        check("skip241", written.exists(241), 0);
        check("skip242", written.exists(242), 0);
        check("skip481", written.exists(481), 0);
        check("skip482", written.exists(482), 0);
`else
        check("solidCount", wrCnt - w0, 16);
        check("solid241", written.exists(241), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
